// File: rtl/or_reduce_pipe.sv
// Parametrised OR-reduction tree with a valid shift chain, a sticky accumulate flag
// and a saturating hit counter; reset is asynchronous and clears every register.
module or_reduce_pipe #(
  parameter int N_IN  = 16,
  parameter int GROUP = 4,
  parameter int PIPE  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_data,
  input  logic             sticky_en,
  input  logic             sticky_clr,
  output logic             out_valid,
  output logic             out_or,
  output logic             out_sticky,
  output logic [CNT_W-1:0] hit_cnt
);

  function automatic int level_width(input int k);
    int w;
    w = N_IN;
    for (int i = 0; i < k; i++) w = (w + GROUP - 1) / GROUP;
    return w;
  endfunction

  function automatic int num_levels();
    int w;
    int n;
    w = N_IN;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (w > 1) begin
        w = (w + GROUP - 1) / GROUP;
        n++;
      end
    end
    return (n < 1) ? 1 : n;
  endfunction

  localparam int L   = num_levels();
  localparam int LAT = (PIPE != 0) ? L : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Level 0 is the masked input; level k ORs consecutive GROUP-bit chunks of level k-1.
  for (genvar gk = 0; gk <= L; gk++) begin : g_lvl
    localparam int WO = level_width(gk);
    logic [WO-1:0] src;

    if (gk == 0) begin : g_in
      // Invalid beats enter as zero so don't-care data can never reach out_or.
      assign src = in_valid ? in_data : '0;
    end else begin : g_node
      localparam int WI = level_width(gk - 1);
      logic [WO-1:0] node_d;

      for (genvar gj = 0; gj < WO; gj++) begin : g_or
        logic [GROUP-1:0] chunk;
        for (genvar gg = 0; gg < GROUP; gg++) begin : g_bit
          if (gj * GROUP + gg < WI) begin : g_use
            assign chunk[gg] = g_lvl[gk-1].src[gj*GROUP+gg];
          end else begin : g_pad
            assign chunk[gg] = 1'b0;
          end
        end
        assign node_d[gj] = |chunk;
      end

      // The last level is always registered; inner levels only when pipelined.
      if (PIPE != 0 || gk == L) begin : g_reg
        logic [WO-1:0] node_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) node_q <= '0;
          else     node_q <= node_d;
        end
        assign src = node_q;
      end else begin : g_comb
        assign src = node_d;
      end
    end
  end

  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] valid_d;

  always_comb begin
    valid_d    = valid_q << 1;
    valid_d[0] = in_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  assign out_valid = valid_q[LAT-1];
  assign out_or    = out_valid & g_lvl[L].src[0];

  logic             qual;
  logic             sticky_q;
  logic             sticky_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign qual = out_valid & sticky_en;

  // A clear coincident with a qualifying beat opens a new window containing that beat.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (sticky_clr) begin
      sticky_d = qual & out_or;
      cnt_d    = '0;
      cnt_d[0] = qual & out_or;
    end else if (qual) begin
      sticky_d = sticky_q | out_or;
      if (out_or && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_sticky = sticky_q;
  assign hit_cnt    = cnt_q;

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Directed bench: a 16-bit/GROUP=4 pipelined instance with a 3-bit counter driven from a
// vector table, plus two 5-bit GROUP=2 instances (PIPE=0 and PIPE=1) swept exhaustively.
module tb_or_reduce_pipe;

  logic        clk;
  logic        rst;

  logic        a_valid;
  logic [15:0] a_data;
  logic        a_en;
  logic        a_clr;
  logic        a_ovalid;
  logic        a_oor;
  logic        a_osticky;
  logic [2:0]  a_cnt;

  logic        s_valid;
  logic [4:0]  s_data;
  logic        b_ovalid;
  logic        b_oor;
  logic        b_osticky;
  logic [7:0]  b_cnt;
  logic        c_ovalid;
  logic        c_oor;
  logic        c_osticky;
  logic [7:0]  c_cnt;

  int n_vec;
  int n_miss;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        en;
    logic        clr;
    logic        ev;
    logic        eor;
    logic        est;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t tbl[$];

  or_reduce_pipe #(.N_IN(16), .GROUP(4), .PIPE(1), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data),
    .sticky_en(a_en), .sticky_clr(a_clr), .out_valid(a_ovalid), .out_or(a_oor),
    .out_sticky(a_osticky), .hit_cnt(a_cnt)
  );

  or_reduce_pipe #(.N_IN(5), .GROUP(2), .PIPE(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data),
    .sticky_en(1'b0), .sticky_clr(1'b0), .out_valid(b_ovalid), .out_or(b_oor),
    .out_sticky(b_osticky), .hit_cnt(b_cnt)
  );

  or_reduce_pipe #(.N_IN(5), .GROUP(2), .PIPE(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data),
    .sticky_en(1'b0), .sticky_clr(1'b0), .out_valid(c_ovalid), .out_or(c_oor),
    .out_sticky(c_osticky), .hit_cnt(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end else begin
      $display("ok   %s[%0d]: %h", name, idx, act);
    end
  endtask

  function automatic logic [7:0] a_pack();
    return {2'b00, a_ovalid, a_oor, a_osticky, a_cnt};
  endfunction

  function automatic logic [7:0] a_exp(input logic v, input logic o, input logic s, input logic [2:0] c);
    return {2'b00, v, o, s, c};
  endfunction

  task automatic add(input logic v, input logic [15:0] d, input logic en, input logic clr,
                     input logic ev, input logic eor, input logic est, input logic [2:0] ecnt);
    vec_t r;
    r.v = v; r.d = d; r.en = en; r.clr = clr;
    r.ev = ev; r.eor = eor; r.est = est; r.ecnt = ecnt;
    tbl.push_back(r);
  endtask

  initial begin
    int j;
    logic [7:0] eb;
    logic [7:0] ec;
    n_vec  = 0;
    n_miss = 0;

    // Each row: inputs held for one cycle, outputs expected just after that cycle's edge.
    // Beat in row i appears in row i+1; sticky/count change from row i's outputs shows in row i+1.
    add(1'b1, 16'h8000, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 3'd0); // 0
    add(1'b0, 16'hFFFF, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 3'd0); // 1
    add(1'b1, 16'h0000, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 3'd0); // 2 streaming
    add(1'b1, 16'h0001, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 3'd0); // 3
    add(1'b1, 16'h0000, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 3'd0); // 4
    add(1'b1, 16'h0100, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 3'd0); // 5
    add(1'b0, 16'hFFFF, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 3'd0); // 6
    add(1'b0, 16'h0000, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 3'd0); // 7
    add(1'b1, 16'h0000, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 3'd0); // 8 sticky window
    add(1'b1, 16'h0010, 1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 3'd0); // 9
    add(1'b1, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 3'd0); // 10
    add(1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 3'd1); // 11
    add(1'b0, 16'h0000, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 3'd1); // 12
    add(1'b0, 16'h0000, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 3'd0); // 13 clear alone
    add(1'b1, 16'h0200, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 3'd0); // 14
    add(1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 3'd0); // 15
    add(1'b0, 16'h0000, 1'b1, 1'b1,  1'b0, 1'b0, 1'b1, 3'd1); // 16 clear with hit
    add(1'b1, 16'hFFFF, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 3'd0); // 17 saturation, 9 beats
    add(1'b1, 16'hFFFF, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 3'd0); // 18
    add(1'b1, 16'hFFFF, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 3'd1); // 19
    add(1'b1, 16'hFFFF, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 3'd2); // 20
    add(1'b1, 16'hFFFF, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 3'd3); // 21
    add(1'b1, 16'hFFFF, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 3'd4); // 22
    add(1'b1, 16'hFFFF, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 3'd5); // 23
    add(1'b1, 16'hFFFF, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 3'd6); // 24
    add(1'b1, 16'hFFFF, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 3'd7); // 25
    add(1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 3'd7); // 26
    add(1'b0, 16'h0000, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 3'd7); // 27
    add(1'b0, 16'h0000, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 3'd7); // 28
    add(1'b0, 16'h0000, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 3'd0); // 29
    add(1'b1, 16'h0001, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 3'd0); // 30 sticky_en=0 holds
    add(1'b1, 16'h0001, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 3'd0); // 31
    add(1'b0, 16'h0000, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 3'd0); // 32
    add(1'b0, 16'h0000, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 3'd0); // 33
    add(1'b1, 16'h4000, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 3'd0); // 34
    add(1'b1, 16'h0800, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 3'd0); // 35
    add(1'b1, 16'h0020, 1'b1, 1'b0,  1'b1, 1'b1, 1'b1, 3'd1); // 36
    add(1'b0, 16'h0000, 1'b1, 1'b1,  1'b1, 1'b1, 1'b1, 3'd1); // 37 clear restarts at 1
    add(1'b0, 16'h0000, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 3'd2); // 38
    add(1'b0, 16'h0000, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 3'd2); // 39
    add(1'b1, 16'h0000, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 3'd2); // 40
    add(1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b0, 1'b1, 3'd2); // 41
    add(1'b0, 16'h0000, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 3'd0); // 42 clear with zero result
    add(1'b1, 16'h0001, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 3'd0); // 43
    add(1'b0, 16'h0000, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 3'd0); // 44
    add(1'b0, 16'h0000, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 3'd1); // 45

    // Reset held with valid random traffic: everything stays at zero.
    rst = 1'b1;
    a_valid = 1'b1; a_data = 16'h0; a_en = 1'b1; a_clr = 1'b0;
    s_valid = 1'b0; s_data = 5'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_data = 16'($urandom);
      @(posedge clk); #1;
      chk("reset_hold", i, a_pack(), a_exp(1'b0, 1'b0, 1'b0, 3'd0));
    end
    @(negedge clk);
    a_valid = 1'b0;
    a_en    = 1'b0;
    rst     = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      a_valid = tbl[i].v;
      a_data  = tbl[i].d;
      a_en    = tbl[i].en;
      a_clr   = tbl[i].clr;
      @(posedge clk); #1;
      chk("table", i, a_pack(), a_exp(tbl[i].ev, tbl[i].eor, tbl[i].est, tbl[i].ecnt));
    end

    // Mid-flight asynchronous reset with sticky/count nonzero.
    @(negedge clk);
    a_valid = 1'b1; a_data = 16'h0004; a_en = 1'b0; a_clr = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst", 0, a_pack(), a_exp(1'b0, 1'b0, 1'b1, 3'd1));
    #1 rst = 1'b1;
    #1;
    chk("rst_async", 0, a_pack(), a_exp(1'b0, 1'b0, 1'b0, 3'd0));
    a_valid = 1'b0;
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_data = 16'hFFFF;
      @(posedge clk); #1;
      chk("rst_flush", i, a_pack(), a_exp(1'b0, 1'b0, 1'b0, 3'd0));
    end
    @(negedge clk);
    a_valid = 1'b1; a_data = 16'h0002;
    @(posedge clk); #1;
    chk("post_rst", 0, a_pack(), a_exp(1'b0, 1'b0, 1'b0, 3'd0));
    @(negedge clk);
    a_valid = 1'b0; a_data = 16'h0;
    @(posedge clk); #1;
    chk("post_rst", 1, a_pack(), a_exp(1'b1, 1'b1, 1'b0, 3'd0));
    @(negedge clk);
    @(posedge clk); #1;
    chk("post_rst", 2, a_pack(), a_exp(1'b0, 1'b0, 1'b0, 3'd0));

    // Exhaustive 5-bit sweep: PIPE=0 shows beat k in row k, PIPE=1 (3 levels) in row k+2.
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (k < 32) begin
        s_valid = 1'b1;
        s_data  = 5'(k);
      end else begin
        s_valid = 1'b0;
        s_data  = 5'h1F;
      end
      @(posedge clk); #1;
      eb = (k < 32) ? {6'b0, 1'b1, (k != 0)} : 8'h00;
      j  = k - 2;
      ec = (j >= 0 && j < 32) ? {6'b0, 1'b1, (j != 0)} : 8'h00;
      chk("sweep_pipe0", k, {6'b0, b_ovalid, b_oor}, eb);
      chk("sweep_pipe1", k, {6'b0, c_ovalid, c_oor}, ec);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
